// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the imem/dmem request ports and the SRAM port.
//               master = core + SRAM side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_i;
    logic [ADDR_WIDTH-1:0] imem_addr_i;
    logic [DATA_WIDTH-1:0] imem_rdata_o;
    logic                  imem_ack_o;

    logic                  dmem_req_i;
    logic                  dmem_we_i;
    logic [ADDR_WIDTH-1:0] dmem_addr_i;
    logic [DATA_WIDTH-1:0] dmem_wdata_i;
    logic [DATA_WIDTH-1:0] dmem_rdata_o;
    logic                  dmem_ack_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  busy_o;

    modport master (
        output imem_req_i, imem_addr_i,
        input  imem_rdata_o, imem_ack_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_rdata_o, dmem_ack_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  busy_o
    );

    modport slave (
        input  imem_req_i, imem_addr_i,
        output imem_rdata_o, imem_ack_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        output dmem_rdata_o, dmem_ack_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises imem/dmem requests onto one synchronous SRAM port,
//               dmem priority, EXTRA_WAIT wait states, one-cycle ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int EXTRA_WAIT = 0
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    mem_port_arbiter_if.slave  bus
);
    localparam int C_CNT_W = (EXTRA_WAIT > 0) ? $clog2(EXTRA_WAIT + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD =
        C_CNT_W'((EXTRA_WAIT > 0) ? EXTRA_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_LATCH  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner_d;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [C_CNT_W-1:0]    r_cnt;
    logic                  w_grant_d;
    logic                  w_grant_i;

    assign w_grant_d = bus.dmem_req_i;
    assign w_grant_i = bus.imem_req_i & ~bus.dmem_req_i;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_d || w_grant_i) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_LATCH;
            S_LATCH:  w_state_nxt = (EXTRA_WAIT > 0) ? S_WAIT : S_RESP;
            S_WAIT:   if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields are captured only at grant; later changes are ignored.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_owner_d <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
        end else begin
            if ((r_state == S_IDLE) && (w_grant_d || w_grant_i)) begin
                r_owner_d <= w_grant_d;
                r_addr    <= w_grant_d ? bus.dmem_addr_i : bus.imem_addr_i;
                r_we      <= w_grant_d & bus.dmem_we_i;
                r_wdata   <= w_grant_d ? bus.dmem_wdata_i : '0;
            end
            if (r_state == S_LATCH) begin
                if (!r_we) begin
                    r_rdata <= bus.mem_rdata_i;
                end
                r_cnt <= C_CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - C_CNT_W'(1);
            end
        end
    end

    assign bus.mem_en_o     = (r_state == S_ACCESS);
    assign bus.mem_we_o     = (r_state == S_ACCESS) & r_we;
    assign bus.mem_addr_o   = r_addr;
    assign bus.mem_wdata_o  = r_wdata;
    assign bus.imem_ack_o   = (r_state == S_RESP) & ~r_owner_d;
    assign bus.dmem_ack_o   = (r_state == S_RESP) &  r_owner_d;
    assign bus.imem_rdata_o = r_rdata;
    assign bus.dmem_rdata_o = r_rdata;
    assign bus.busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter between the `simple_processor` core's instruction (`imem_*`) and data (`dmem_*`) req/ack ports and one synchronous single-port SRAM. It serialises the two request streams onto one memory port with fixed data priority, inserts a programmable number of wait states, and returns read data with a one-cycle ack pulse. It replaces the combinational `ack = req` tie-off in system benches, so the core sees realistic, non-zero memory latency.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports.
- `DATA_WIDTH`, 32, data width of all ports.
- `EXTRA_WAIT`, 0, additional wait cycles per access; legal range 0..15.
- `clk_i` in 1: clock; all state updates on rising edge.
- `arst_ni` in 1: asynchronous, active-low reset.
- `imem_req_i` in 1: fetch request, held until `imem_ack_o`.
- `imem_addr_i` in ADDR_WIDTH: fetch address.
- `imem_rdata_o` out DATA_WIDTH: fetch data, valid only while `imem_ack_o`=1.
- `imem_ack_o` out 1: one-cycle completion pulse.
- `dmem_req_i` in 1: data request, held until `dmem_ack_o`.
- `dmem_we_i` in 1: 1 = write, 0 = read.
- `dmem_addr_i` in ADDR_WIDTH: data address.
- `dmem_wdata_i` in DATA_WIDTH: write data.
- `dmem_rdata_o` out DATA_WIDTH: read data, valid only while `dmem_ack_o`=1 on a read.
- `dmem_ack_o` out 1: one-cycle completion pulse.
- `mem_en_o` out 1: SRAM enable, one cycle per access.
- `mem_we_o` out 1: SRAM write enable, qualified by `mem_en_o`.
- `mem_addr_o` out ADDR_WIDTH: SRAM address.
- `mem_wdata_o` out DATA_WIDTH: SRAM write data.
- `mem_rdata_i` in DATA_WIDTH: SRAM read data, valid the cycle after `mem_en_o`.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, LATCH, WAIT, RESP.
- IDLE: if `dmem_req_i`, grant dmem; else if `imem_req_i`, grant imem. Both high means dmem wins. On grant, register owner, addr, we (imem: we=0) and wdata, then go to ACCESS.
- ACCESS: `mem_en_o`=1; `mem_we_o`, `mem_addr_o`, `mem_wdata_o` come from the registered values. Next state is LATCH.
- LATCH: on a read, load `mem_rdata_i` into the shared rdata register at the end of the cycle; on a write, leave it unchanged. Next state is WAIT if `EXTRA_WAIT`>0, else RESP. The wait counter loads `EXTRA_WAIT`-1.
- WAIT: decrement the counter; move to RESP when it reaches 0. The counter is `$clog2(EXTRA_WAIT+1)` bits wide (minimum 1).
- RESP: assert the owner's ack for exactly one cycle, then go to IDLE. The non-owner's ack stays 0.
- `imem_rdata_o` and `dmem_rdata_o` are both driven from the shared rdata register.
- Request inputs are sampled only in IDLE. Changes to addr, we or wdata after the grant are ignored.
- If a requester drops req mid-transaction (protocol violation), the transaction still completes and the ack still pulses.
- Requests left pending at ack time are not reused. A req still high in the cycle after the ack is treated as a new request.

## Timing
- Reset values: all acks 0, `mem_en_o` 0, `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, rdata register 0, `busy_o` 0, state IDLE, counter 0.
- Reset asserted in any state forces IDLE immediately, with no ack and no `mem_en_o`. The in-flight access is abandoned; a write already issued in ACCESS may have reached the SRAM.
- Latency: req seen in IDLE in cycle 0; ACCESS in cycle 1; LATCH in cycle 2; ack in cycle 3+`EXTRA_WAIT`.
- Throughput: one access per 4+`EXTRA_WAIT` cycles. IDLE always lasts at least one cycle between transactions.
- Starvation: under continuous dmem requests, imem waits. This is acceptable because the core stalls fetch during data operations.
- All outputs are registered or decoded from state only; there is no combinational path from `*_req_i` to any output.

## Test plan
- Single imem read, `EXTRA_WAIT`=0, addr 0x1000, SRAM holds 0xDEADBEEF there -> `mem_en_o` in cycle 1; `imem_ack_o` exactly one cycle in cycle 3 with `imem_rdata_o`=0xDEADBEEF; `dmem_ack_o` stays 0.
- Simultaneous imem (0x1000) and dmem read (0x2000) in cycle 0 -> dmem acked in cycle 3; imem is granted in the following IDLE cycle (4) and acked in cycle 7.
- dmem write 0x12345678 to 0x2004, then dmem read of 0x2004 -> write ack carries `mem_we_o`=1 during ACCESS; the read returns 0x12345678; rdata register is unchanged across the write.
- `EXTRA_WAIT`=3, imem read -> ack in cycle 6 and `busy_o` high for cycles 1-6. Repeat with `EXTRA_WAIT`=15 -> ack in cycle 18.
- Reset pulsed during WAIT -> all outputs at reset values immediately and no ack ever emitted. A fresh request after release completes with normal latency.
- Addr changed and req dropped during ACCESS -> SRAM sees the original addr and the ack still pulses in cycle 3.
